// File: rtl/sel_minmax_reg.sv
// rtl/sel_minmax_reg.sv - registered N-way unsigned min/max selector
// Balanced compare tree picks {value, index}; lower index wins ties; one output register stage.
module sel_minmax_reg #(
  parameter int MINMAX_ = 1,
  parameter int IN      = 8,
  parameter int DATA    = 8,
  parameter int ACT     = 1,
  parameter int OUT     = $clog2(IN)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [IN-1:0][DATA-1:0]   in,
  output logic [OUT-1:0]            out_idx,
  output logic [IN-1:0]             out_vec,
  output logic [DATA-1:0]           out
);

  localparam int LVL = $clog2(IN);

  logic [DATA-1:0] tv [LVL+1][IN];
  logic [OUT-1:0]  ti [LVL+1][IN];

  logic [OUT-1:0]  out_idx_d, out_idx_q;
  logic [IN-1:0]   out_vec_d, out_vec_q;
  logic [DATA-1:0] out_d, out_q;
  logic [IN-1:0]   onehot;

  always_comb begin
    int n;
    int r;
    for (int l = 0; l <= LVL; l++) begin
      for (int k = 0; k < IN; k++) begin
        tv[l][k] = '0;
        ti[l][k] = '0;
      end
    end
    for (int k = 0; k < IN; k++) begin
      tv[0][k] = in[k];
      ti[0][k] = OUT'(k);
    end
    n = IN;
    r = 0;
    // Left child always holds the lower indices, so it wins unless the right is strictly better.
    for (int l = 1; l <= LVL; l++) begin
      for (int j = 0; j < (IN + 1) / 2; j++) begin
        r = (2 * j + 1 < IN) ? 2 * j + 1 : 2 * j;
        if (2 * j + 1 < n) begin
          if ((MINMAX_ != 0) ? (tv[l-1][r] < tv[l-1][2*j]) : (tv[l-1][r] > tv[l-1][2*j])) begin
            tv[l][j] = tv[l-1][r];
            ti[l][j] = ti[l-1][r];
          end else begin
            tv[l][j] = tv[l-1][2*j];
            ti[l][j] = ti[l-1][2*j];
          end
        end else if (2 * j < n) begin
          tv[l][j] = tv[l-1][2*j];
          ti[l][j] = ti[l-1][2*j];
        end
      end
      n = (n + 1) / 2;
    end
  end

  always_comb begin
    onehot = '0;
    for (int k = 0; k < IN; k++) begin
      onehot[k] = (ti[LVL][0] == OUT'(k));
    end
    out_idx_d = ti[LVL][0];
    out_d     = tv[LVL][0];
    out_vec_d = (ACT != 0) ? onehot : ~onehot;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_idx_q <= '0;
      out_q     <= '0;
      out_vec_q <= (ACT != 0) ? '0 : '1;
    end else begin
      out_idx_q <= out_idx_d;
      out_q     <= out_d;
      out_vec_q <= out_vec_d;
    end
  end

  assign out_idx = out_idx_q;
  assign out_vec = out_vec_q;
  assign out     = out_q;

endmodule

// File: tb/tb_sel_minmax_reg.sv
// tb/tb_sel_minmax_reg.sv - self-checking bench for sel_minmax_reg
// Six configurations share one input bus; expectations are hand constants plus a linear-scan model.
module tb_sel_minmax_reg;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0][7:0] in8 = '0;

  always #5 clk = ~clk;

  logic [2:0] idx_a, idx_b, idx_c, idx_d, idx_e, idx_f;
  logic [7:0] vec_a, vec_b, vec_c, vec_d;
  logic [4:0] vec_e, vec_f;
  logic [7:0] out_a, out_b, out_c, out_d, out_e, out_f;

  sel_minmax_reg #(.MINMAX_(1), .IN(8), .DATA(8), .ACT(1)) u_min_a1 (
    .clk(clk), .reset(reset), .in(in8), .out_idx(idx_a), .out_vec(vec_a), .out(out_a));
  sel_minmax_reg #(.MINMAX_(0), .IN(8), .DATA(8), .ACT(1)) u_max_a1 (
    .clk(clk), .reset(reset), .in(in8), .out_idx(idx_b), .out_vec(vec_b), .out(out_b));
  sel_minmax_reg #(.MINMAX_(1), .IN(8), .DATA(8), .ACT(0)) u_min_a0 (
    .clk(clk), .reset(reset), .in(in8), .out_idx(idx_c), .out_vec(vec_c), .out(out_c));
  sel_minmax_reg #(.MINMAX_(0), .IN(8), .DATA(8), .ACT(0)) u_max_a0 (
    .clk(clk), .reset(reset), .in(in8), .out_idx(idx_d), .out_vec(vec_d), .out(out_d));
  sel_minmax_reg #(.MINMAX_(1), .IN(5), .DATA(8), .ACT(1)) u_min5_a1 (
    .clk(clk), .reset(reset), .in(in8[4:0]), .out_idx(idx_e), .out_vec(vec_e), .out(out_e));
  sel_minmax_reg #(.MINMAX_(0), .IN(5), .DATA(8), .ACT(0)) u_max5_a0 (
    .clk(clk), .reset(reset), .in(in8[4:0]), .out_idx(idx_f), .out_vec(vec_f), .out(out_f));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int scan_idx(input logic [7:0][7:0] v, input int n, input bit mn);
    int b = 0;
    for (int k = 1; k < n; k++) begin
      if (mn ? (v[k] < v[b]) : (v[k] > v[b])) b = k;
    end
    return b;
  endfunction

  task automatic chk_inst(input string tag, input logic [7:0][7:0] v, input int n, input bit mn,
                          input bit act, input logic [31:0] gi, input logic [31:0] gv,
                          input logic [31:0] go);
    int e;
    logic [31:0] oh, msk;
    e   = scan_idx(v, n, mn);
    oh  = 32'd1 << e;
    msk = (32'd1 << n) - 32'd1;
    check({tag, "_idx"}, gi, 32'(e));
    check({tag, "_out"}, go, {24'd0, v[e]});
    check({tag, "_vec"}, gv, act ? oh : (~oh & msk));
  endtask

  task automatic chk_model(input logic [7:0][7:0] v);
    chk_inst("min_a1",  v, 8, 1'b1, 1'b1, 32'(idx_a), 32'(vec_a), 32'(out_a));
    chk_inst("max_a1",  v, 8, 1'b0, 1'b1, 32'(idx_b), 32'(vec_b), 32'(out_b));
    chk_inst("min_a0",  v, 8, 1'b1, 1'b0, 32'(idx_c), 32'(vec_c), 32'(out_c));
    chk_inst("max_a0",  v, 8, 1'b0, 1'b0, 32'(idx_d), 32'(vec_d), 32'(out_d));
    chk_inst("min5_a1", v, 5, 1'b1, 1'b1, 32'(idx_e), 32'(vec_e), 32'(out_e));
    chk_inst("max5_a0", v, 5, 1'b0, 1'b0, 32'(idx_f), 32'(vec_f), 32'(out_f));
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_idx_a"}, 32'(idx_a), 0);  check({tag, "_out_a"}, 32'(out_a), 0);
    check({tag, "_vec_a"}, 32'(vec_a), 0);  check({tag, "_vec_b"}, 32'(vec_b), 0);
    check({tag, "_vec_c"}, 32'(vec_c), 32'hFF);
    check({tag, "_vec_d"}, 32'(vec_d), 32'hFF);
    check({tag, "_idx_d"}, 32'(idx_d), 0);  check({tag, "_out_d"}, 32'(out_d), 0);
    check({tag, "_vec_e"}, 32'(vec_e), 0);
    check({tag, "_vec_f"}, 32'(vec_f), 32'h1F);
    check({tag, "_out_f"}, 32'(out_f), 0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [7:0][7:0] v1;
  logic [7:0][7:0] hold;

  initial begin
    v1[0] = 8'h50; v1[1] = 8'h20; v1[2] = 8'h90; v1[3] = 8'h20;
    v1[4] = 8'h33; v1[5] = 8'hFF; v1[6] = 8'h21; v1[7] = 8'h40;

    #12;
    chk_reset("por");
    reset = 1'b0;
    in8 = v1;
    tick;
    check("v1_min_idx", 32'(idx_a), 1);
    check("v1_min_out", 32'(out_a), 32'h20);
    check("v1_min_vec", 32'(vec_a), 32'h02);
    check("v1_max_idx", 32'(idx_b), 5);
    check("v1_max_out", 32'(out_b), 32'hFF);
    check("v1_max_vec", 32'(vec_b), 32'h20);
    check("v1_mina0_vec", 32'(vec_c), 32'hFD);
    check("v1_min5_idx", 32'(idx_e), 1);
    check("v1_max5_idx", 32'(idx_f), 2);
    check("v1_max5_vec", 32'(vec_f), 32'h1B);
    chk_model(in8);

    in8 = {8{8'h7A}};
    tick;
    check("eq_max_idx", 32'(idx_b), 0);
    check("eq_max_out", 32'(out_b), 32'h7A);
    check("eq_max_vec", 32'(vec_b), 32'h01);
    chk_model(in8);

    in8 = {8{8'h80}};
    in8[7] = 8'h00;
    tick;
    check("last_mina0_idx", 32'(idx_c), 7);
    check("last_mina0_out", 32'(out_c), 0);
    check("last_mina0_vec", 32'(vec_c), 32'h7F);
    check("last_min5_idx", 32'(idx_e), 0);
    chk_model(in8);

    in8 = '0;
    tick;
    check("zero_min_idx", 32'(idx_a), 0);
    check("zero_max_out", 32'(out_b), 0);
    chk_model(in8);

    in8 = '1;
    tick;
    check("ones_max_idx", 32'(idx_b), 0);
    check("ones_min_out", 32'(out_a), 32'hFF);
    chk_model(in8);

    in8 = v1;
    tick;
    #3 reset = 1'b1;
    #1 chk_reset("async");
    in8 = {8{8'h11}};
    in8[6] = 8'h01;
    tick;
    chk_reset("hold1");
    in8[2] = 8'hEE;
    tick;
    chk_reset("hold2");
    reset = 1'b0;
    hold = in8;
    tick;
    check("rel_min_idx", 32'(idx_a), 6);
    check("rel_max_idx", 32'(idx_b), 2);
    chk_model(hold);

    for (int c = 0; c < 1000; c++) begin
      for (int k = 0; k < 8; k++) begin
        in8[k] = (c % 2 == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      end
      hold = in8;
      tick;
      chk_model(hold);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sel_minmax_reg.md
Name: sel_minmax_reg

Overview:
- Registered N-way minimum/maximum selector.
- Compares IN unsigned DATA-bit inputs and reports the extreme value, its binary index, and a one-hot select vector whose active polarity is set by a parameter.
- Used wherever a datapath picks the oldest/smallest/largest entry among parallel candidates.
- Combinational compare tree followed by one output register stage.

Parameters:
- MINMAX_, 1, selection mode: 1 = select minimum, 0 = select maximum.
- IN, 8, number of candidate inputs; must be >= 2; non-power-of-two values supported.
- DATA, 8, width of each candidate in bits.
- ACT, 1, active level of out_vec: 1 = selected bit high, others low; 0 = selected bit low, others high.
- OUT, $clog2(IN), index width (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in  input  [IN-1:0][DATA-1:0]  packed candidate array; in[k] is candidate k.
- out_idx  output  OUT  binary index of the selected candidate.
- out_vec  output  IN  one-hot select vector, polarity per ACT.
- out  output  DATA  value of the selected candidate.

Behaviour:
- Comparison: unsigned, full DATA width.
- MINMAX_=1: selects the smallest in[k].
- MINMAX_=0: selects the largest in[k].
- Tie-break: among equal extreme values, the lowest index wins. Equivalent to a linear scan from k=0 that replaces the current pick only on strict less-than (min) or strict greater-than (max).
- out_vec: exactly one bit at the active level (ACT), at position out_idx; all other bits at the inactive level.
- out: always equals in[out_idx] as sampled on the same edge.
- Latency: 1 cycle.
  - in is sampled on each rising clk edge.
  - out_idx, out_vec and out reflect that sample from the same edge until the next edge.
  - No valid/enable handshake; a new result every cycle (throughput 1 per cycle).
- Internals:
  - Selection is a balanced binary compare tree of depth ceil(log2 IN).
  - Each node forwards {value, index}; on equality the lower-index child wins.
  - Odd nodes pass through unchanged.
  - The three outputs are registered together and always mutually consistent.
- Reset (asynchronous, immediate on reset high, independent of clk):
  - out_idx = 0.
  - out = 0.
  - out_vec = all bits inactive (all 0 if ACT=1, all 1 if ACT=0).
- Reset release: first valid result appears after the first rising edge with reset low.
- Reset mid-operation: the in-flight result is discarded; outputs go straight to reset values.
- Boundaries:
  - All inputs equal: idx 0.
  - All-zero inputs: idx 0, out 0.
  - All-ones inputs: idx 0, out all ones.
  - Extreme value at index IN-1: idx IN-1.
- Unknown/X inputs: not required to be handled.

Test Plan:
- Default params (min, IN=8, DATA=8, ACT=1); in = {k: 0x50,0x20,0x90,0x20,0x33,0xFF,0x21,0x40} for k=0..7 -> after one edge: out_idx=1, out=0x20, out_vec=0x02 (tie with k=3 resolves to lower index).
- MINMAX_=0, same inputs -> out_idx=5, out=0xFF, out_vec=0x20. Then all inputs 0x7A -> out_idx=0, out=0x7A, out_vec=0x01.
- ACT=0, MINMAX_=1, only in[7]=0x00 and all others 0x80 -> out_idx=7, out=0x00, out_vec=0x7F.
- Reset:
  - Assert reset asynchronously mid-cycle -> outputs immediately out_idx=0, out=0, out_vec=0x00 (0xFF when ACT=0).
  - Hold for 2 edges with varying in -> outputs stay at reset values.
  - Deassert -> result for the sampled in appears after the next edge.
- Randomized: 1000 cycles of $random inputs per mode (min/max × ACT 0/1), plus IN=5 and IN=8 configurations -> each cycle all outputs match a reference linear scan (strict compare, lowest index on tie) of the previous cycle's inputs.
